ysyx_23060236_writeback_arbiter: RTL

//  Write side of the GPR file. Arbitrates completed results from EXU and LSU into one registered write port.

---
 rtl/ysyx_23060236_writeback_arbiter_pkg.sv | 14 +
 rtl/ysyx_23060236_writeback_arbiter_scoreboard.sv | 77 +++++++
 rtl/ysyx_23060236_writeback_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_writeback_arbiter_pkg.sv
// Shared definitions for the GPR write-back arbiter: grant encoding and default widths.
// Imported by the arbiter top and by its pending-write scoreboard.
package ysyx_23060236_writeback_arbiter_pkg;

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 2;

endpackage

// File: rtl/ysyx_23060236_writeback_arbiter_scoreboard.sv
// Per-register pending-write counters; decode uses busy1/busy2 to stall RAW hazards.
// Register 0 is never incremented, so its counter stays at zero.
module ysyx_23060236_scoreboard
    import ysyx_23060236_writeback_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  dec_valid,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  all_zero
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic                 inc_en;
    logic                 dec_en;

    assign issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);
    assign inc_en      = issue_valid && issue_ready && (issue_rd != '0);
    assign dec_en      = dec_valid && (dec_rd != '0);

    // Increment applied first, so an inc and dec on one register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en) begin
            cnt_d[issue_rd] = cnt_d[issue_rd] + CNT_WIDTH'(1);
        end
        if (dec_en && (cnt_q[dec_rd] != '0)) begin
            cnt_d[dec_rd] = cnt_d[dec_rd] - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (cnt_q[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    assign busy1 = (raddr1 != '0) && (cnt_q[raddr1] != '0);
    assign busy2 = (raddr2 != '0) && (cnt_q[raddr2] != '0);

    // A retire with no pending issue means the producer broke protocol.
    always @(posedge clock) begin
        if (!reset && dec_en) begin
            assert (cnt_q[dec_rd] != '0);
        end
    end

endmodule

// File: rtl/ysyx_23060236_writeback_arbiter.sv
// Arbitrates EXU and LSU results into one registered GPR write port and
// tracks pending destinations through the scoreboard sub-module.
module ysyx_23060236_writeback_arbiter
    import ysyx_23060236_writeback_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic                  exu_wen,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic                  rf_wen,
    output logic                  rf_valid,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  idle
);

    grant_e                last_grant_q, last_grant_d;
    logic                  grant_exu, grant_lsu;
    logic                  rf_valid_q, rf_valid_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  sb_all_zero;

    // Handshake: a source holds valid/rd/data stable until its ready is high;
    // the result transfers on the edge where valid && ready. Ready depends only
    // on the valids and last_grant, never on any ready.
    always_comb begin
        grant_exu    = 1'b0;
        grant_lsu    = 1'b0;
        last_grant_d = last_grant_q;
        if (exu_valid && lsu_valid) begin
            if (last_grant_q == GNT_EXU) begin
                grant_lsu    = 1'b1;
                last_grant_d = GNT_LSU;
            end else begin
                grant_exu    = 1'b1;
                last_grant_d = GNT_EXU;
            end
        end else if (exu_valid) begin
            grant_exu = 1'b1;
        end else if (lsu_valid) begin
            grant_lsu = 1'b1;
        end
    end

    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;

    // Address/data hold their last value when idle; only valid/wen matter then.
    always_comb begin
        rf_valid_d = grant_exu || grant_lsu;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_lsu) begin
            rf_waddr_d = lsu_rd;
            rf_wdata_d = lsu_data;
            rf_wen_d   = (lsu_rd != '0);
        end else if (grant_exu) begin
            rf_waddr_d = exu_rd;
            rf_wdata_d = exu_data;
            rf_wen_d   = exu_wen && (exu_rd != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= GNT_EXU;
            rf_valid_q   <= 1'b0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_valid_q   <= rf_valid_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_valid = rf_valid_q;
    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    ysyx_23060236_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .dec_valid   (rf_valid_q && rf_wen_q),
        .dec_rd      (rf_waddr_q),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .busy1       (busy1),
        .busy2       (busy2),
        .all_zero    (sb_all_zero)
    );

    assign idle = sb_all_zero && !rf_valid_q;

endmodule
